// File: rtl/uc_arbiter.sv
// uc_arbiter: round-robin unit-clause arbiter. Pops at most one head literal per
// cycle from the per-PE implication queues into a one-entry stage, then
// broadcasts it to every PE's UCQ_out only when none of them is full.
//
// Optional feature macro: UCARB_DEDUP_EN
//   defined   -> per-variable (pos, neg) assignment table; duplicates are
//                dropped, contradictions raise a sticky ucarb_conflict.
//   undefined -> no table; every valid literal is broadcast, conflict tied 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   UCQ_in_empty        per-PE implication-queue empty
//   UCQ_in2uarb_uc      per-PE head literal (signed, LIT_W bits)
//   ucarb2UCQ_in_pop    one-hot pop to the granted PE (combinational)
//   UCQ_out_full        per-PE UCQ_out full
//   ucarb2UCQ_out_push  broadcast push to all PEs (combinational)
//   ucarb2UCQ_out_uc    broadcast literal (the staged literal)
//   clear               synchronous flush for a new propagation round
//   ucarb_conflict      sticky contradictory-implication flag
//   ucarb_idle          stage empty and all input queues empty
//   bcast_count         saturating count of broadcast literals

`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 8
`endif

module uc_arbiter #(
  parameter int unsigned NUM_PE  = 4,
  parameter int unsigned LIT_W   = `LIT_IDX_MAX*2,
  parameter int unsigned NUM_VAR = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PE-1:0]              UCQ_in_empty,
  input  logic [NUM_PE-1:0][LIT_W-1:0]   UCQ_in2uarb_uc,
  output logic [NUM_PE-1:0]              ucarb2UCQ_in_pop,
  input  logic [NUM_PE-1:0]              UCQ_out_full,
  output logic                           ucarb2UCQ_out_push,
  output logic [LIT_W-1:0]               ucarb2UCQ_out_uc,
  input  logic                           clear,
  output logic                           ucarb_conflict,
  output logic                           ucarb_idle,
  output logic [15:0]                    bcast_count
);

  localparam int unsigned PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [LIT_W:0] VAR_LIM = (LIT_W+1)'(NUM_VAR);

  logic              stage_v;
  logic [LIT_W-1:0]  stage_lit;
  logic [PE_W-1:0]   rr_ptr;
  logic              conflict_q;

  logic              any_full_c;
  logic              lit_neg_c;
  logic [LIT_W-1:0]  lit_mag_c;
  logic              lit_ok_c;
  logic              dup_c;
  logic              contra_c;
  logic              active_c;
  logic              push_c;
  logic              stage_free_c;
  logic              grant_c;
  logic              gnt_found_c;
  logic [PE_W-1:0]   gnt_idx_c;
  logic [PE_W-1:0]   cand_c;

  // Literal decode: magnitude is the variable index, sign bit is polarity.
  assign any_full_c = |UCQ_out_full;
  assign lit_neg_c  = stage_lit[LIT_W-1];
  assign lit_mag_c  = lit_neg_c ? (~stage_lit + LIT_W'(1)) : stage_lit;
  assign lit_ok_c   = (stage_lit != '0) && ({1'b0, lit_mag_c} < VAR_LIM);

`ifdef UCARB_DEDUP_EN
  localparam int unsigned VIDX_W = $clog2(NUM_VAR);

  logic [NUM_VAR-1:0] asg_pos;
  logic [NUM_VAR-1:0] asg_neg;
  logic [VIDX_W-1:0]  var_idx_c;

  assign var_idx_c = lit_mag_c[VIDX_W-1:0];
  assign dup_c     = lit_ok_c & (lit_neg_c ? asg_neg[var_idx_c] : asg_pos[var_idx_c]);
  assign contra_c  = lit_ok_c & (lit_neg_c ? asg_pos[var_idx_c] : asg_neg[var_idx_c]);
`else
  assign dup_c     = 1'b0;
  assign contra_c  = 1'b0;
`endif

  // Retire decision: invalid/duplicate drop, contradiction holds, else push when nobody is full.
  assign active_c     = stage_v & ~conflict_q & ~clear;
  assign push_c       = active_c & lit_ok_c & ~dup_c & ~contra_c & ~any_full_c;
  assign stage_free_c = ~stage_v | (active_c & (~lit_ok_c | dup_c | push_c));
  assign grant_c      = stage_free_c & ~conflict_q & ~clear & gnt_found_c;

  // Round-robin search starting after rr_ptr; scanning from lowest priority
  // upward lets the highest-priority candidate be the last one written.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    cand_c      = '0;
    for (int k = int'(NUM_PE); k >= 1; k--) begin
      cand_c = PE_W'((int'(rr_ptr) + k) % int'(NUM_PE));
      if (!UCQ_in_empty[cand_c]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = cand_c;
      end
    end
  end

  // One-hot pop for the granted PE.
  always_comb begin
    ucarb2UCQ_in_pop = '0;
    if (grant_c) ucarb2UCQ_in_pop[gnt_idx_c] = 1'b1;
  end

  assign ucarb2UCQ_out_push = push_c;
  assign ucarb2UCQ_out_uc   = stage_lit;
  assign ucarb_idle         = ~stage_v & (&UCQ_in_empty);
  assign ucarb_conflict     = conflict_q;

  // Stage and round-robin pointer; a grant refills the stage as it retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_v   <= 1'b0;
      stage_lit <= '0;
      rr_ptr    <= PE_W'(NUM_PE - 1);
    end else if (clear) begin
      stage_v   <= 1'b0;
    end else if (grant_c) begin
      stage_v   <= 1'b1;
      stage_lit <= UCQ_in2uarb_uc[gnt_idx_c];
      rr_ptr    <= gnt_idx_c;
    end else if (stage_free_c) begin
      stage_v   <= 1'b0;
    end
  end

  // Saturating broadcast counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcast_count <= '0;
    end else if (clear) begin
      bcast_count <= '0;
    end else if (push_c && (bcast_count != 16'hFFFF)) begin
      bcast_count <= bcast_count + 16'd1;
    end
  end

`ifdef UCARB_DEDUP_EN
  // Sticky conflict flag and per-variable assignment table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
      asg_pos    <= '0;
      asg_neg    <= '0;
    end else if (clear) begin
      conflict_q <= 1'b0;
      asg_pos    <= '0;
      asg_neg    <= '0;
    end else begin
      if (active_c && contra_c) conflict_q <= 1'b1;
      if (push_c) begin
        if (lit_neg_c) asg_neg[var_idx_c] <= 1'b1;
        else           asg_pos[var_idx_c] <= 1'b1;
      end
    end
  end
`else
  assign conflict_q = 1'b0;
`endif

endmodule

// File: doc/uc_arbiter.md
# uc_arbiter

Unit-clause arbiter between the per-PE implication queues and the per-PE input queues of all `proc` instances. Each cycle it selects at most one non-empty `UCQ_in` by round-robin, pops its head literal into a one-entry stage, and broadcasts that literal to every PE's `UCQ_out` once none of them is full. An optional assignment table drops duplicate implications and flags contradictory ones as a global conflict.

## Interface
Parameters:
- `NUM_PE`, 4: number of `proc` instances served.
- `LIT_W`, `` `LIT_IDX_MAX*2 ``: literal width; signed two's complement, matching `lit_t`.
- `NUM_VAR`, 256: variable-table depth. Valid variable index is 1..NUM_VAR-1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `UCQ_in_empty`  in  NUM_PE  per-PE implication-queue empty.
- `UCQ_in2uarb_uc`  in  NUM_PE×LIT_W  per-PE head literal (registered queue head).
- `ucarb2UCQ_in_pop`  out  NUM_PE  one-hot pop; at most one bit set.
- `UCQ_out_full`  in  NUM_PE  per-PE `UCQ_out` full.
- `ucarb2UCQ_out_push`  out  1  broadcast push, wired to every PE.
- `ucarb2UCQ_out_uc`  out  LIT_W  broadcast literal.
- `clear`  in  1  synchronous flush that starts a new propagation round.
- `ucarb_conflict`  out  1  sticky contradictory-implication flag.
- `ucarb_idle`  out  1  stage empty and all `UCQ_in_empty` set.
- `bcast_count`  out  16  literals broadcast since the last reset or clear; saturates at 0xFFFF.

## Operation
- State: `stage_v`, `stage_lit`, `rr_ptr` (last granted PE), `ucarb_conflict`, `bcast_count`, and (when configured) `asg[NUM_VAR]` with 2 bits per variable (pos, neg).
- Arbitration: the candidate set is the PEs with `UCQ_in_empty`=0. Priority starts at `rr_ptr+1` and wraps modulo NUM_PE.
- A grant occurs only when `stage_v`=0, or the stage is retiring this cycle, and `ucarb_conflict`=0.
- On grant: assert the pop bit for the granted PE, load `stage_lit` from that PE's head, set `stage_v`, and set `rr_ptr` to the granted PE.
- Stage retire is evaluated each cycle with `stage_v`=1 and no conflict:
  - Invalid literal (0, or |lit| ≥ NUM_VAR): drop it. No push.
  - Duplicate (table bit for the same polarity already set): drop it. No push.
  - Contradiction (opposite-polarity bit set): set `ucarb_conflict` and leave `stage_v` set. No push.
  - Otherwise, push only if every bit of `UCQ_out_full` is 0. The push sets the table bit and increments `bcast_count`. If any bit is full, hold the stage.
- The broadcast is all-or-nothing. A literal is never pushed to a subset of PEs.
- Conflict is sticky: no pops and no pushes until `clear` or reset.
- `clear`: clears `stage_v`, `ucarb_conflict`, all `asg` bits, and `bcast_count`. `rr_ptr` is kept. The staged literal is discarded. No pop or push occurs in the `clear` cycle.

## Timing
- Reset values: `ucarb2UCQ_in_pop`=0, `ucarb2UCQ_out_push`=0, `ucarb2UCQ_out_uc`=0, `ucarb_conflict`=0, `bcast_count`=0, `ucarb_idle`=1 when all queues are empty, `rr_ptr`=NUM_PE-1 (PE0 has first priority), table all zero.
- Pop outputs are combinational from state and `UCQ_in_empty`. `ucarb2UCQ_out_push` is combinational from the stage, the table lookup and `UCQ_out_full`. `ucarb2UCQ_out_uc` equals `stage_lit`.
- Latency: pop in cycle N gives the earliest push in cycle N+1.
- Throughput: 1 literal/cycle. A pop and a retire in the same cycle are allowed.
- The table update from a push in cycle N is visible to the lookup in cycle N+1. Back-to-back identical literals are therefore correctly deduplicated.
- `clear` and a grant in the same cycle: `clear` wins and no pop occurs.
- Reset asserted mid-broadcast: all state returns to reset values asynchronously. The in-flight literal is lost.

## Configuration
- `UCARB_DEDUP_EN` defined: the `asg` table is present and behaves as described above (duplicate drop, contradiction conflict).
- Not defined: no table. Every valid literal is broadcast. `ucarb_conflict` is tied to 0. Invalid literals are still dropped.

## Test plan
- Single PE0 pushes +5 with all `UCQ_out` not full → pop[0] in cycle N, push of +5 in N+1, `bcast_count`=1.
- PE0..PE3 all non-empty from reset → grants in order 0,1,2,3,0; one pop per cycle; pushes in consecutive cycles.
- Stage holds +7 while `UCQ_out_full[2]`=1 for 3 cycles → push is 0 for those 3 cycles, no further pops, push of +7 on the first cycle with all not full.
- (DEDUP) broadcast +9, then PE1 implies +9 → second +9 popped, not pushed, `bcast_count` unchanged. PE2 then implies -9 → `ucarb_conflict`=1 and all pops stop.
- Conflict active, assert `clear` for 1 cycle → `ucarb_conflict`=0, `bcast_count`=0. -9 is then accepted and broadcast.
- Literal 0 and +NUM_VAR injected → both popped and dropped, no push. Assert `rst_n`=0 mid-hold → all outputs return to reset values immediately.
